// File: rtl/fpu_pkg.sv
// Shared definitions for the custom 32-bit float format and its converters.
// Field layout: sign[31], exponent[30:21] (bias 511), mantissa[20:0] with hidden 1.
package fpu_pkg;

    localparam int unsigned WORD_W   = 32;
    localparam int unsigned EXP_MSB  = 30;
    localparam int unsigned EXP_LSB  = 21;
    localparam int unsigned MANT_W   = 21;
    localparam int unsigned EXP_BIAS = 511;

    typedef enum logic [1:0] {
        EXACT     = 2'd0,
        INEXACT   = 2'd1,
        UNDERFLOW = 2'd2,
        OVERFLOW  = 2'd3
    } status_t;

    typedef enum logic [2:0] {
        IDLE,
        UNPACK,
        SHIFT,
        PACK,
        HOLD
    } conv_state_t;

    typedef enum logic [2:0] {
        CLS_ZERO,
        CLS_UNDERFLOW,
        CLS_FRAC,
        CLS_SAT,
        CLS_NORMAL
    } fp_class_t;

    function automatic logic [WORD_W-1:0] sat_value(input logic sign);
        return sign ? 32'h8000_0000 : 32'h7FFF_FFFF;
    endfunction

endpackage

// File: rtl/fp_to_int_if.sv
// Operand and result handshake bundle between the FPU result bus and fp_to_int.
interface fp_to_int_if;
    import fpu_pkg::*;

    logic [31:0] fp_in;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] int_out;
    status_t     status_out;
    logic        out_valid;
    logic        out_ready;

    modport master (
        output fp_in,
        output in_valid,
        output out_ready,
        input  in_ready,
        input  int_out,
        input  status_out,
        input  out_valid
    );

    modport slave (
        input  fp_in,
        input  in_valid,
        input  out_ready,
        output in_ready,
        output int_out,
        output status_out,
        output out_valid
    );

endinterface

// File: rtl/fp_field_decode.sv
// Combinational field decoder: splits a custom-format word into sign, significand,
// shift direction/amount and a value class. Shared with the FPU DECODE stage.
module fp_field_decode #(
    parameter int unsigned EXP_BIAS    = fpu_pkg::EXP_BIAS,
    parameter int unsigned SHIFT_CNT_W = 5
) (
    input  logic [31:0]                word,
    output logic                       sign,
    output logic [fpu_pkg::MANT_W:0]   sig,
    output logic                       shift_left,
    output logic [SHIFT_CNT_W-1:0]     shift_amt,
    output fpu_pkg::fp_class_t         fclass
);
    import fpu_pkg::*;

    logic [EXP_MSB-EXP_LSB:0] exp_field;
    logic [MANT_W-1:0]        mant_field;
    int                       k;

    assign sign       = word[WORD_W-1];
    assign exp_field  = word[EXP_MSB:EXP_LSB];
    assign mant_field = word[MANT_W-1:0];
    assign sig        = {1'b1, mant_field};

    // value = sig * 2^k with the binary point after the mantissa LSB
    always_comb begin
        k          = int'(exp_field) - int'(EXP_BIAS) - int'(MANT_W);
        fclass     = CLS_NORMAL;
        shift_left = 1'b0;
        shift_amt  = '0;
        if (exp_field == '0) begin
            fclass = (mant_field == '0) ? CLS_ZERO : CLS_UNDERFLOW;
        end else if (k < -int'(MANT_W)) begin
            fclass = CLS_FRAC;
        end else if (k > int'(WORD_W) - 2 - int'(MANT_W)) begin
            fclass = CLS_SAT;
        end else if (k < 0) begin
            shift_amt = SHIFT_CNT_W'(-k);
        end else begin
            shift_left = 1'b1;
            shift_amt  = SHIFT_CNT_W'(k);
        end
    end

endmodule

// File: rtl/fp_to_int.sv
// Multi-cycle custom-float to signed 32-bit integer converter, one conversion in
// flight, valid/ready on both sides, shifting the significand one bit per cycle.
module fp_to_int #(
    parameter int unsigned EXP_BIAS    = 511,
    parameter int unsigned SHIFT_CNT_W = 5
) (
    input  logic        clock_100Khz,
    input  logic        reset,
    fp_to_int_if.slave  bus
);
    import fpu_pkg::*;

    conv_state_t            state_q, state_d;
    logic [31:0]            fp_q, fp_d;
    logic [31:0]            mag_q, mag_d;
    logic                   sticky_q, sticky_d;
    logic [SHIFT_CNT_W-1:0] cnt_q, cnt_d;
    logic                   sign_q, sign_d;
    logic                   left_q, left_d;
    fp_class_t              cls_q, cls_d;
    logic [31:0]            int_q, int_d;
    status_t                status_q, status_d;
    logic                   out_valid_q, out_valid_d;

    logic                   dec_sign;
    logic [MANT_W:0]        dec_sig;
    logic                   dec_left;
    logic [SHIFT_CNT_W-1:0] dec_amt;
    fp_class_t              dec_cls;

    fp_field_decode #(
        .EXP_BIAS    (EXP_BIAS),
        .SHIFT_CNT_W (SHIFT_CNT_W)
    ) u_decode (
        .word       (fp_q),
        .sign       (dec_sign),
        .sig        (dec_sig),
        .shift_left (dec_left),
        .shift_amt  (dec_amt),
        .fclass     (dec_cls)
    );

    assign bus.in_ready   = (state_q == IDLE);
    assign bus.int_out    = int_q;
    assign bus.status_out = status_q;
    assign bus.out_valid  = out_valid_q;

    always_comb begin
        state_d     = state_q;
        fp_d        = fp_q;
        mag_d       = mag_q;
        sticky_d    = sticky_q;
        cnt_d       = cnt_q;
        sign_d      = sign_q;
        left_d      = left_q;
        cls_d       = cls_q;
        int_d       = int_q;
        status_d    = status_q;
        out_valid_d = out_valid_q;

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    fp_d    = bus.fp_in;
                    state_d = UNPACK;
                end
            end
            UNPACK: begin
                sign_d   = dec_sign;
                cls_d    = dec_cls;
                left_d   = dec_left;
                cnt_d    = dec_amt;
                mag_d    = 32'(dec_sig);
                sticky_d = 1'b0;
                if (dec_cls != CLS_NORMAL || dec_amt == '0) begin
                    state_d = PACK;
                end else begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (left_q) begin
                    mag_d = mag_q << 1;
                end else begin
                    mag_d    = mag_q >> 1;
                    sticky_d = sticky_q | mag_q[0];
                end
                cnt_d = cnt_q - SHIFT_CNT_W'(1);
                if (cnt_q == SHIFT_CNT_W'(1)) begin
                    state_d = PACK;
                end
            end
            PACK: begin
                case (cls_q)
                    CLS_ZERO: begin
                        int_d    = '0;
                        status_d = EXACT;
                    end
                    CLS_UNDERFLOW: begin
                        int_d    = '0;
                        status_d = UNDERFLOW;
                    end
                    CLS_FRAC: begin
                        int_d    = '0;
                        status_d = INEXACT;
                    end
                    CLS_SAT: begin
                        int_d    = sat_value(sign_q);
                        status_d = OVERFLOW;
                    end
                    default: begin
                        // negative zero falls through as plain zero
                        int_d    = (sign_q && mag_q != '0) ? (~mag_q + 32'd1) : mag_q;
                        status_d = sticky_q ? INEXACT : EXACT;
                    end
                endcase
                out_valid_d = 1'b1;
                state_d     = HOLD;
            end
            HOLD: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock_100Khz or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            fp_q        <= '0;
            mag_q       <= '0;
            sticky_q    <= 1'b0;
            cnt_q       <= '0;
            sign_q      <= 1'b0;
            left_q      <= 1'b0;
            cls_q       <= CLS_ZERO;
            int_q       <= '0;
            status_q    <= EXACT;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            fp_q        <= fp_d;
            mag_q       <= mag_d;
            sticky_q    <= sticky_d;
            cnt_q       <= cnt_d;
            sign_q      <= sign_d;
            left_q      <= left_d;
            cls_q       <= cls_d;
            int_q       <= int_d;
            status_q    <= status_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule
